// File: rtl/vr16_pc_pkg.sv
// Shared types and default vectors for the VR16 fetch-stage program counter.
package vr16_pc_pkg;

  // One action per advancing cycle, listed in priority order after HOLD.
  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_RESTART,
    CMD_CALL,
    CMD_RET,
    CMD_BRANCH,
    CMD_INC
  } pc_cmd_t;

  localparam logic [15:0] DEF_RESET_VECTOR = 16'h0000;
  localparam logic [15:0] DEF_TRAP_VECTOR  = 16'hFFF0;

endpackage

// File: rtl/pc_ras_unit_if.sv
// Control-unit <-> program-counter bundle: command strobes in, pc and stack status out.
interface pc_ras_unit_if #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8
);
  localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

  logic              advance;
  logic              restart;
  logic              call_en;
  logic [ADDR_W-1:0] call_target;
  logic              ret_en;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_offset;
  logic              err_clear;
  logic [ADDR_W-1:0] pc;
  logic [LVL_W-1:0]  stack_level;
  logic              stack_full;
  logic              stack_empty;
  logic              overflow_err;
  logic              underflow_err;

  // Control unit side
  modport master (
    output advance, restart, call_en, call_target, ret_en, branch_en,
           branch_offset, err_clear,
    input  pc, stack_level, stack_full, stack_empty, overflow_err, underflow_err
  );

  // Program counter side
  modport slave (
    input  advance, restart, call_en, call_target, ret_en, branch_en,
           branch_offset, err_clear,
    output pc, stack_level, stack_full, stack_empty, overflow_err, underflow_err
  );
endinterface

// File: rtl/return_addr_stack.sv
// LIFO of return addresses. Push when full and pop when empty are ignored.
// The top entry is read combinationally so a value pushed on one edge can be
// popped on the very next edge.
module return_addr_stack #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int LVL_W = $clog2(DEPTH) + 1,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);
  // Entry storage has no reset: contents are meaningless once level drops.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] top_lvl;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign top_lvl = level_q - LVL_W'(1);
  assign dout_o  = mem_q[top_lvl[IDX_W-1:0]];
  assign level_o = level_q;

  // Write the pushed address into the slot just above the current top.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[level_q[IDX_W-1:0]] <= din_i;
  end

  // Next fill level: clear beats push beats pop.
  always_comb begin
    level_d = level_q;
    if (clear_i)      level_d = '0;
    else if (do_push) level_d = level_q + LVL_W'(1);
    else if (do_pop)  level_d = level_q - LVL_W'(1);
  end

  // Fill level register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= '0;
    else       level_q <= level_d;
  end
endmodule

// File: rtl/pc_ras_unit.sv
// VR16 program counter with return-address stack, relative branches, restart
// vector and sticky stack overflow/underflow flags.
module pc_ras_unit
  import vr16_pc_pkg::*;
#(
  parameter int              ADDR_W       = 16,
  parameter int              STACK_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
  parameter logic [ADDR_W-1:0] TRAP_VECTOR  = ADDR_W'(DEF_TRAP_VECTOR)
) (
  input logic         clk,
  input logic         reset,
  pc_ras_unit_if.slave bus
);
  localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

  pc_cmd_t           cmd;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] ras_top;
  logic [LVL_W-1:0]  ras_level;
  logic              ras_full, ras_empty;

  return_addr_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .clear_i (cmd == CMD_RESTART),
    .push_i  (cmd == CMD_CALL),
    .pop_i   (cmd == CMD_RET),
    .din_i   (pc_q + ADDR_W'(1)),
    .dout_o  (ras_top),
    .level_o (ras_level),
    .full_o  (ras_full),
    .empty_o (ras_empty)
  );

  // Pick the single highest-priority action for this cycle.
  always_comb begin
    cmd = CMD_HOLD;
    if (bus.advance) begin
      if (bus.restart)        cmd = CMD_RESTART;
      else if (bus.call_en)   cmd = CMD_CALL;
      else if (bus.ret_en)    cmd = CMD_RET;
      else if (bus.branch_en) cmd = CMD_BRANCH;
      else                    cmd = CMD_INC;
    end
  end

  // Next pc and flags; err_clear acts even without advance, but a set event wins.
  always_comb begin
    pc_d  = pc_q;
    ovf_d = bus.err_clear ? 1'b0 : ovf_q;
    unf_d = bus.err_clear ? 1'b0 : unf_q;
    unique case (cmd)
      CMD_RESTART: pc_d = RESET_VECTOR;
      CMD_CALL: begin
        pc_d = bus.call_target;
        if (ras_full) ovf_d = 1'b1;
      end
      CMD_RET: begin
        if (ras_empty) begin
          pc_d  = TRAP_VECTOR;
          unf_d = 1'b1;
        end else begin
          pc_d = ras_top;
        end
      end
      CMD_BRANCH: pc_d = pc_q + bus.branch_offset;
      CMD_INC:    pc_d = pc_q + ADDR_W'(1);
      default:    pc_d = pc_q;
    endcase
  end

  // pc and sticky error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.stack_level   = ras_level;
  assign bus.stack_full    = ras_full;
  assign bus.stack_empty   = ras_empty;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;
endmodule

// File: tb/tb_pc_ras_unit.sv
// Bench for pc_ras_unit: directed scenarios then random command mix, all
// compared against a queue-based reference model.
module tb_pc_ras_unit;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  // Reference model state
  logic [15:0] m_pc;
  logic [15:0] m_stack [$];
  logic        m_ovf, m_unf;

  pc_ras_unit_if #(.ADDR_W(16), .STACK_DEPTH(DEPTH)) bus ();

  pc_ras_unit #(.ADDR_W(16), .STACK_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    {16'h0, bus.pc}, {16'h0, m_pc});
    check({tag, ".lvl"},   {28'h0, bus.stack_level}, m_stack.size());
    check({tag, ".full"},  {31'h0, bus.stack_full},  {31'h0, m_stack.size() == DEPTH});
    check({tag, ".empty"}, {31'h0, bus.stack_empty}, {31'h0, m_stack.size() == 0});
    check({tag, ".ovf"},   {31'h0, bus.overflow_err},  {31'h0, m_ovf});
    check({tag, ".unf"},   {31'h0, bus.underflow_err}, {31'h0, m_unf});
  endtask

  // Drive one cycle of commands, update the model at the edge, then compare.
  task automatic step(input string tag, input logic adv, input logic rst,
                      input logic call, input logic ret, input logic br,
                      input logic clr, input logic [15:0] tgt, input logic [15:0] off);
    bus.advance = adv;  bus.restart = rst;  bus.call_en = call;
    bus.ret_en = ret;   bus.branch_en = br; bus.err_clear = clr;
    bus.call_target = tgt; bus.branch_offset = off;
    @(posedge clk);
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (adv) begin
      if (rst) begin
        m_pc = 16'h0000;
        m_stack.delete();
      end else if (call) begin
        if (m_stack.size() == DEPTH) m_ovf = 1'b1;
        else m_stack.push_back(m_pc + 16'd1);
        m_pc = tgt;
      end else if (ret) begin
        if (m_stack.size() == 0) begin
          m_pc = 16'hFFF0;
          m_unf = 1'b1;
        end else begin
          m_pc = m_stack.pop_back();
        end
      end else if (br) begin
        m_pc = m_pc + off;
      end else begin
        m_pc = m_pc + 16'd1;
      end
    end
    #1;
    check_all(tag);
    $display("[%0t] %s pc=%h lvl=%0d ovf=%b unf=%b", $time, tag, bus.pc,
             bus.stack_level, bus.overflow_err, bus.underflow_err);
  endtask

  task automatic inc(input string tag);
    step(tag, 1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic call(input string tag, input logic [15:0] tgt);
    step(tag, 1, 0, 1, 0, 0, 0, tgt, 16'h0);
  endtask

  task automatic ret(input string tag);
    step(tag, 1, 0, 0, 1, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic go_to(input string tag, input logic [15:0] target);
    step(tag, 1, 0, 0, 0, 1, 0, 16'h0, target - m_pc);
  endtask

  initial begin
    bus.advance = 0; bus.restart = 0; bus.call_en = 0; bus.ret_en = 0;
    bus.branch_en = 0; bus.err_clear = 0; bus.call_target = '0; bus.branch_offset = '0;
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b0;

    // Sequential fetch from the reset vector
    for (int i = 0; i < 5; i++) inc("inc");
    check("inc5", {16'h0, bus.pc}, 32'h5);

    // Single call / return round trip
    go_to("goto10", 16'h0010);
    call("call200", 16'h0200);
    check("call.lvl1", {28'h0, bus.stack_level}, 32'd1);
    for (int i = 0; i < 3; i++) inc("body");
    ret("ret");
    check("ret.pc", {16'h0, bus.pc}, 32'h0011);

    // Nine nested calls overflow, nine returns underflow
    for (int i = 0; i < 9; i++) call("nest", 16'h1000 + 16'(i * 16));
    check("nest.ovf", {31'h0, bus.overflow_err}, 32'd1);
    check("nest.pc",  {16'h0, bus.pc}, 32'h1080);
    for (int i = 0; i < 8; i++) ret("unwind");
    ret("ret.empty");
    check("trap.pc", {16'h0, bus.pc}, 32'hFFF0);

    // Clear flags, then simultaneous strobes
    step("clr", 0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
    step("call+ret+br", 1, 0, 1, 1, 1, 0, 16'h0345, 16'h0007);
    step("rst+call", 1, 1, 1, 0, 0, 0, 16'h0777, 16'h0);

    // Wrap at all-ones and negative branch
    go_to("gotoFFFF", 16'hFFFF);
    inc("wrap");
    for (int i = 0; i < 4; i++) inc("inc");
    step("br-6", 1, 0, 0, 0, 1, 0, 16'h0, 16'hFFFA);
    check("br-6.pc", {16'h0, bus.pc}, 32'hFFFE);
    step("hold.call", 0, 0, 1, 0, 0, 0, 16'h0123, 16'h0);

    // Asynchronous reset mid-cycle with three nested calls
    for (int i = 0; i < 3; i++) call("pre", 16'h0400 + 16'(i));
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2 reset = 1'b0;

    // err_clear in the same cycle as an overflow: set wins
    for (int i = 0; i < DEPTH; i++) call("fill", 16'h0500 + 16'(i));
    step("ovf+clr", 1, 0, 1, 0, 0, 1, 16'h0600, 16'h0);
    check("ovf+clr.ovf", {31'h0, bus.overflow_err}, 32'd1);

    // Random command mix
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
           16'($urandom), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
Parametrised program counter for the VR16 fetch stage, with a hardware return-address stack (RAS) for nested calls.
- Replaces the single-entry return register with a LIFO of configurable depth.
- Adds PC-relative branches, a restart vector, and sticky stack overflow/underflow error flags.
- Sits between the control unit, which drives the command strobes, and instruction memory, which is addressed by pc.

Parameters:
ADDR_W, 16, PC and address width in bits
STACK_DEPTH, 8, number of RAS entries (power of two, minimum 2)
RESET_VECTOR, 0, pc value after reset and after restart
TRAP_VECTOR, 16'hFFF0, pc loaded on return with an empty stack (ADDR_W bits)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
advance  input  1  step enable; no state changes when low
restart  input  1  soft restart (control-unit flag code 2'b11)
call_en  input  1  jump to call_target and push return address
call_target  input  ADDR_W  absolute call destination
ret_en  input  1  pop return address into pc
branch_en  input  1  PC-relative branch
branch_offset  input  ADDR_W  signed two's-complement offset
err_clear  input  1  clears sticky error flags
pc  output  ADDR_W  current program counter
stack_level  output  $clog2(STACK_DEPTH)+1  number of valid RAS entries
stack_full  output  1  stack_level == STACK_DEPTH
stack_empty  output  1  stack_level == 0
overflow_err  output  1  sticky; call attempted while full
underflow_err  output  1  sticky; return attempted while empty

Behaviour:
- Reset (async, any time, including mid-sequence):
  - pc = RESET_VECTOR, stack_level = 0, both error flags 0.
  - RAS contents are don't-care and are not cleared.
- All updates happen on the rising clk edge when advance=1. When advance=0, every register holds, including under command strobes.
- Command priority when advance=1, exactly one action per cycle:
  - restart > call_en > ret_en > branch_en > increment.
  - Lower-priority strobes asserted in the same cycle are ignored entirely, with no side effects.
- restart: pc <= RESET_VECTOR; stack_level <= 0; error flags unchanged.
- call_en:
  - pc <= call_target.
  - Pushes pc+1 (modulo 2^ADDR_W), the address of the instruction after the call.
  - If full: the push is dropped, the jump still occurs, stack_level stays at STACK_DEPTH, overflow_err <= 1.
- ret_en:
  - If not empty: pc <= top entry; stack_level decrements.
  - If empty: pc <= TRAP_VECTOR; underflow_err <= 1; stack_level stays 0.
- branch_en: pc <= pc + branch_offset, truncated to ADDR_W (wraps both ways).
- Increment: pc <= pc + 1; all-ones wraps to 0.
- Latency: pc reflects the command in the cycle after the strobe edge. The stack top is readable in that same cycle.
- Error flags:
  - err_clear=1 clears both flags regardless of advance.
  - A set event in the same cycle as err_clear wins (flag = 1).
- stack_full and stack_empty are combinational decodes of stack_level.
- Push then immediate pop in consecutive cycles must return the just-pushed value (no bypass hazard; write occurs on the push edge).

Decomposition:
- Shared package vr16_pc_pkg:
  - pc_cmd_t enum: CMD_HOLD, CMD_RESTART, CMD_CALL, CMD_RET, CMD_BRANCH, CMD_INC.
  - Default RESET_VECTOR and TRAP_VECTOR constants.
- Sub-module return_addr_stack (params WIDTH, DEPTH):
  - Ports: push, pop, din, dout (top), level, full, empty.
  - Ignores push when full and pop when empty.
- pc_ras_unit holds the priority decode, the pc register, and the error flags.

Test Plan:
- Reset, then advance=1 for 5 cycles -> pc = 0,1,2,3,4,5; stack_empty=1; errors 0.
- At pc=0x0010, call_en with target 0x0200; 3 increments; then ret_en -> pc = 0x0200, 0x0201, 0x0202, 0x0203, then 0x0011; stack_level goes 1 then 0.
- STACK_DEPTH=8: nine nested calls -> overflow_err=1 after the 9th, stack_level=8, pc = 9th target. Eight returns then yield the 8 pushed addresses in LIFO order. The 9th return -> pc=0xFFF0 and underflow_err=1.
- Same cycle: call_en+ret_en+branch_en -> call only. restart+call_en -> pc=0, stack_level=0, no push.
- pc=0xFFFF with increment -> 0x0000. pc=0x0004 with branch_offset=0xFFFA (-6) -> 0xFFFE. advance=0 with call_en -> no change.
- Assert reset asynchronously mid-clock during nested calls (stack_level=3) -> pc=0, stack_level=0, flags 0 immediately, before the next edge. err_clear together with an overflow event -> overflow_err remains 1.
